// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one single-port ROM between instruction fetch (IF) and load unit (LS).
// Define ROM_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (LS beats IF).
module rom_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iIF_REQ,
  input  logic [ADDR_W-1:0] iIF_ADDR,
  output logic              oIF_GNT,
  output logic              oIF_RVALID,
  input  logic              iIF_RREADY,
  output logic [DATA_W-1:0] oIF_RDATA,
  input  logic              iLS_REQ,
  input  logic [ADDR_W-1:0] iLS_ADDR,
  output logic              oLS_GNT,
  output logic              oLS_RVALID,
  input  logic              iLS_RREADY,
  output logic [DATA_W-1:0] oLS_RDATA,
  output logic              oROM_CE,
  output logic              oROM_RD,
  output logic [ADDR_W-1:0] oROM_ADDR,
  input  logic [DATA_W-1:0] iROM_DATA
);

  // state  | meaning
  // IDLE   | no transaction; sample requests and pick a winner
  // ACCESS | ROM enabled at addr_q; data captured at end of cycle
  // RESP   | owner's RVALID held until owner's RREADY
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state;
  logic              owner_ls;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] rdata_q;
  logic              pick_ls;
  logic              owner_rready;

`ifdef ROM_ARB_FIXED_PRIO_EN
  assign pick_ls = iLS_REQ;
`else
  logic last_ls;

  // On a tie the requester that was not granted last wins.
  assign pick_ls = iLS_REQ & (~iIF_REQ | ~last_ls);
`endif

  assign owner_rready = owner_ls ? iLS_RREADY : iIF_RREADY;

  assign oROM_ADDR = addr_q;
  assign oIF_RDATA = rdata_q;
  assign oLS_RDATA = rdata_q;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state      <= IDLE;
      owner_ls   <= 1'b0;
      addr_q     <= '0;
      rdata_q    <= '0;
      oIF_GNT    <= 1'b0;
      oLS_GNT    <= 1'b0;
      oIF_RVALID <= 1'b0;
      oLS_RVALID <= 1'b0;
      oROM_CE    <= 1'b0;
      oROM_RD    <= 1'b0;
`ifndef ROM_ARB_FIXED_PRIO_EN
      last_ls    <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (iIF_REQ || iLS_REQ) begin
            state    <= ACCESS;
            owner_ls <= pick_ls;
            addr_q   <= pick_ls ? iLS_ADDR : iIF_ADDR;
            oIF_GNT  <= ~pick_ls;
            oLS_GNT  <= pick_ls;
            oROM_CE  <= 1'b1;
            oROM_RD  <= 1'b1;
`ifndef ROM_ARB_FIXED_PRIO_EN
            last_ls  <= pick_ls;
`endif
          end
        end
        ACCESS: begin
          state      <= RESP;
          rdata_q    <= iROM_DATA;
          oIF_GNT    <= 1'b0;
          oLS_GNT    <= 1'b0;
          oROM_CE    <= 1'b0;
          oROM_RD    <= 1'b0;
          oIF_RVALID <= ~owner_ls;
          oLS_RVALID <= owner_ls;
        end
        RESP: begin
          if (owner_rready) begin
            state      <= IDLE;
            oIF_RVALID <= 1'b0;
            oLS_RVALID <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          oIF_GNT    <= 1'b0;
          oLS_GNT    <= 1'b0;
          oIF_RVALID <= 1'b0;
          oLS_RVALID <= 1'b0;
          oROM_CE    <= 1'b0;
          oROM_RD    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: scoreboard of read data per requester plus a
// transaction-timeline reference model of grants, ROM strobes and response valids.
module tb_rom_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic if_req = 1'b0, ls_req = 1'b0;
  logic [AW-1:0] if_addr = '0, ls_addr = '0;
  logic if_rready = 1'b0, ls_rready = 1'b0;
  logic if_gnt, ls_gnt, if_rvalid, ls_rvalid;
  logic [DW-1:0] if_rdata, ls_rdata;
  logic rom_ce, rom_rd;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] exp_if[$];
  logic [DW-1:0] exp_ls[$];
  int gnt_log[$];
  int gnt_cyc[$];
  logic saw_77 = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return 32'hC0DE_0000 | {24'h0, a};
  endfunction

  // ROM returns garbage unless actually strobed, so off-cycle captures show up.
  assign rom_data = (rom_ce && rom_rd) ? rom_word(rom_addr) : 32'hDEAD_BEEF;

  rom_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .iCLK(clk), .iRST_N(rst_n),
    .iIF_REQ(if_req), .iIF_ADDR(if_addr), .oIF_GNT(if_gnt),
    .oIF_RVALID(if_rvalid), .iIF_RREADY(if_rready), .oIF_RDATA(if_rdata),
    .iLS_REQ(ls_req), .iLS_ADDR(ls_addr), .oLS_GNT(ls_gnt),
    .oLS_RVALID(ls_rvalid), .iLS_RREADY(ls_rready), .oLS_RDATA(ls_rdata),
    .oROM_CE(rom_ce), .oROM_RD(rom_rd), .oROM_ADDR(rom_addr), .iROM_DATA(rom_data)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Reference model: a transaction moves grant -> access cycle -> response until owner ready.
  int cyc = 0;
  int phase = 0;
  logic m_owner = 1'b0;
  logic m_last = 1'b1;
  logic [AW-1:0] m_addr = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      phase = 0; m_last = 1'b1; m_addr = '0;
    end else begin
      case (phase)
        0: if (if_req || ls_req) begin
          if (if_req && ls_req) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
            m_owner = 1'b1;
`else
            m_owner = !m_last;
`endif
          end else begin
            m_owner = ls_req;
          end
          m_last = m_owner;
          m_addr = m_owner ? ls_addr : if_addr;
          phase = 1;
        end
        1: phase = 2;
        default: if (m_owner ? ls_rready : if_rready) phase = 0;
      endcase
    end
  end

  initial forever begin
    logic [5:0] exp_ctrl;
    @(negedge clk);
    #1;
    if (!rst_n) begin
      check("reset_ctrl", 64'({ls_gnt, if_gnt, rom_ce, rom_rd, ls_rvalid, if_rvalid, rom_addr}), 64'(0));
      check("reset_data", {ls_rdata, if_rdata}, 64'(0));
    end else begin
      exp_ctrl = {phase == 1 && m_owner, phase == 1 && !m_owner, phase == 1, phase == 1,
                  phase == 2 && m_owner, phase == 2 && !m_owner};
      check("ctrl", 64'({ls_gnt, if_gnt, rom_ce, rom_rd, ls_rvalid, if_rvalid}), 64'(exp_ctrl));
      check("rom_addr", 64'(rom_addr), 64'(m_addr));
      if (phase == 2) check("rdata_hold", {ls_rdata, if_rdata}, {2{rom_word(m_addr)}});
      if (if_gnt) begin gnt_log.push_back(0); gnt_cyc.push_back(cyc); end
      if (ls_gnt) begin gnt_log.push_back(1); gnt_cyc.push_back(cyc); end
      if (rom_ce && rom_addr == 8'h77) saw_77 = 1'b1;
    end
  end

  // Scoreboard: pop the requester's expected word at each response handshake.
  initial forever begin
    @(negedge clk);
    #1;
    if (rst_n && if_rvalid && if_rready) begin
      if (exp_if.size() == 0) timeout_fail("if_unexpected_resp");
      else check("if_rdata", 64'(if_rdata), 64'(exp_if.pop_front()));
    end
    if (rst_n && ls_rvalid && ls_rready) begin
      if (exp_ls.size() == 0) timeout_fail("ls_unexpected_resp");
      else check("ls_rdata", 64'(ls_rdata), 64'(exp_ls.pop_front()));
    end
  end

  task automatic set_if(input logic r, input logic [AW-1:0] a, input logic rr);
    if_req = r; if_addr = a; if_rready = rr;
  endtask

  task automatic set_ls(input logic r, input logic [AW-1:0] a, input logic rr);
    ls_req = r; ls_addr = a; ls_rready = rr;
  endtask

  task automatic do_txn(input int id, input logic [AW-1:0] a, input int delay);
    int n;
    bit got;
    @(negedge clk);
    if (id == 0) begin set_if(1'b1, a, 1'b0); exp_if.push_back(rom_word(a)); end
    else         begin set_ls(1'b1, a, 1'b0); exp_ls.push_back(rom_word(a)); end
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if ((id == 0) ? if_gnt : ls_gnt) begin got = 1'b1; break; end
    end
    if (!got) begin
      timeout_fail(id == 0 ? "if_grant" : "ls_grant");
      if (id == 0) if_req = 1'b0; else ls_req = 1'b0;
      return;
    end
    // Address and request are scrambled after the grant; the DUT must ignore them.
    if (id == 0) set_if(1'b0, 8'($urandom), delay == 0);
    else         set_ls(1'b0, 8'($urandom), delay == 0);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if ((id == 0) ? if_rvalid : ls_rvalid) begin
        if ((id == 0) ? if_rready : ls_rready) return;
        n++;
        if (n >= delay) begin
          if (id == 0) if_rready = 1'b1; else ls_rready = 1'b1;
          return;
        end
      end
    end
    timeout_fail(id == 0 ? "if_rvalid" : "ls_rvalid");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit got;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Both requesters held busy: alternating grants (or LS always under fixed priority).
    gnt_log.delete();
    fork
      for (int k = 0; k < 4; k++) do_txn(0, 8'h10, 0);
      for (int k = 0; k < 4; k++) do_txn(1, 8'h20, 0);
    join
    if (gnt_log.size() < 4) timeout_fail("rr_order_len");
    else begin
`ifdef ROM_ARB_FIXED_PRIO_EN
      check("grant_order", 64'({gnt_log[3][0], gnt_log[2][0], gnt_log[1][0], gnt_log[0][0]}), 64'(4'b1111));
`else
      check("grant_order", 64'({gnt_log[3][0], gnt_log[2][0], gnt_log[1][0], gnt_log[0][0]}), 64'(4'b1010));
`endif
    end

    // Single IF read.
    do_txn(0, 8'h05, 0);

    // LS response stalled while IF waits.
    fork
      do_txn(1, 8'h3A, 5);
      begin @(negedge clk); do_txn(0, 8'h10, 0); end
    join

    // IF request pulsed during LS response must be lost.
    gnt_log.delete();
    fork
      do_txn(1, 8'h3B, 3);
      begin
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
          @(negedge clk);
          if (ls_rvalid) begin got = 1'b1; break; end
        end
        if (!got) timeout_fail("pulse_wait");
        if_addr = 8'h77; if_req = 1'b1;
        @(negedge clk);
        if_req = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    check("pulse_no_rom_access", 64'(saw_77), 64'(0));
    check("pulse_grants", 64'(gnt_log.size()), 64'(1));

    // Back-to-back IF reads, one per three cycles.
    gnt_cyc.delete();
    for (int a = 0; a < 10; a++) do_txn(0, 8'(a), 0);
    if (gnt_cyc.size() != 10) timeout_fail("b2b_count");
    else check("b2b_spacing", 64'(gnt_cyc[9] - gnt_cyc[0]), 64'(27));

    // Random traffic from both requesters.
    fork
      for (int k = 0; k < 15; k++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        do_txn(0, 8'($urandom), int'($urandom_range(0, 3)));
      end
      for (int j = 0; j < 15; j++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        do_txn(1, 8'($urandom), int'($urandom_range(0, 3)));
      end
    join
    repeat (3) @(negedge clk);
    if_rready = 1'b0; ls_rready = 1'b0;

    // Reset asserted in the middle of an access cycle.
    @(negedge clk);
    if_addr = 8'h42; if_req = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (if_gnt) begin got = 1'b1; break; end
    end
    if (!got) timeout_fail("reset_grant");
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_ctrl", 64'({ls_gnt, if_gnt, rom_ce, rom_rd, ls_rvalid, if_rvalid, rom_addr}), 64'(0));
    check("async_reset_data", {ls_rdata, if_rdata}, 64'(0));
    if_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    gnt_log.delete();
    fork
      do_txn(0, 8'h01, 0);
      do_txn(1, 8'h02, 0);
    join
    if (gnt_log.size() < 1) timeout_fail("post_reset_grant");
    else begin
`ifdef ROM_ARB_FIXED_PRIO_EN
      check("post_reset_first", 64'(gnt_log[0]), 64'(1));
`else
      check("post_reset_first", 64'(gnt_log[0]), 64'(0));
`endif
    end
    repeat (3) @(negedge clk);
    check("sb_drain", 64'(exp_if.size() + exp_ls.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
